// File: rtl/ffcp_rx_sack_server_pkg.sv
// Shared FFCP networking definitions: index/window defaults, packet types,
// packet classification codes and modular index helpers.
package ffcp_rx_sack_server_pkg;

  localparam int FFCP_INDEX_LEN  = 6;
  localparam int FFCP_WINDOW_LEN = 8;
  localparam int FFCP_SACK_W     = FFCP_WINDOW_LEN;

  localparam logic [1:0] FFCP_TYPE_SYN = 2'd0;
  localparam logic [1:0] FFCP_TYPE_MSG = 2'd1;
  localparam logic [1:0] FFCP_TYPE_ACK = 2'd2;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_NEW  = 2'd1,
    CLS_DUP  = 2'd2,
    CLS_IGN  = 2'd3
  } ffcp_cls_e;

  function automatic int clog2(input int unsigned value);
    int res;
    res = 0;
    while ((32'd1 << res) < value) begin
      res = res + 1;
    end
    return res;
  endfunction

  // Distance from head forward to idx, modulo 2^len.
  function automatic logic [31:0] ffcp_index_off(input logic [31:0] idx,
                                                 input logic [31:0] head,
                                                 input int unsigned len);
    logic [31:0] mask;
    mask = (32'd1 << len) - 32'd1;
    return (idx - head) & mask;
  endfunction

endpackage

// File: rtl/ffcp_rx_window.sv
// Receive window store: queue head, arrival bitmap, per-packet classification
// and the one-index-per-cycle head advance.
module ffcp_rx_window
  import ffcp_rx_sack_server_pkg::*;
#(
  parameter int INDEX_LEN  = FFCP_INDEX_LEN,
  parameter int WINDOW_LEN = FFCP_WINDOW_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  syn,
  input  logic                  inclk,
  input  logic [INDEX_LEN-1:0]  in_index,
  output logic [INDEX_LEN-1:0]  head,
  output logic [WINDOW_LEN-1:0] bitmap,
  output logic                  advance,
  output ffcp_cls_e             cls,
  output logic                  new_ooo
);

  localparam logic [31:0] STALE_LO = (32'd1 << INDEX_LEN) - 32'(WINDOW_LEN);

  logic [INDEX_LEN-1:0]  head_r;
  logic [WINDOW_LEN-1:0] bitmap_r;
  logic [INDEX_LEN-1:0]  head_nxt_s;
  logic [WINDOW_LEN-1:0] bitmap_nxt_s;
  logic [INDEX_LEN-1:0]  off_s;
  logic [INDEX_LEN-1:0]  pos_s;
  logic [WINDOW_LEN-1:0] set_mask_s;
  logic                  in_win_s;
  logic                  stale_s;
  logic                  hit_s;

  assign off_s      = INDEX_LEN'(ffcp_index_off(32'(in_index), 32'(head_r), INDEX_LEN));
  assign in_win_s   = 32'(off_s) < 32'(WINDOW_LEN);
  assign stale_s    = 32'(off_s) >= STALE_LO;
  assign hit_s      = |(bitmap_r & (WINDOW_LEN'(1'b1) << off_s));
  assign advance    = bitmap_r[0];
  // While the head moves this cycle the bitmap shifts, so a new bit lands one lower.
  assign pos_s      = advance ? (off_s - INDEX_LEN'(1'b1)) : off_s;
  assign set_mask_s = WINDOW_LEN'(1'b1) << pos_s;
  assign new_ooo    = (cls == CLS_NEW) && (off_s != {INDEX_LEN{1'b0}});
  assign head       = head_r;
  assign bitmap     = bitmap_r;

  // Classify the arriving index against the current window.
  always_comb begin
    cls = CLS_NONE;
    if (inclk && !syn) begin
      if (in_win_s) begin
        if (hit_s) begin
          cls = CLS_DUP;
        end else begin
          cls = CLS_NEW;
        end
      end else if (stale_s) begin
        cls = CLS_DUP;
      end else begin
        cls = CLS_IGN;
      end
    end else begin
      cls = CLS_NONE;
    end
  end

  // Next head/bitmap: syn restart, otherwise advance plus new arrival.
  always_comb begin
    head_nxt_s   = head_r;
    bitmap_nxt_s = bitmap_r;
    if (syn) begin
      head_nxt_s   = INDEX_LEN'(1'b1);
      bitmap_nxt_s = {WINDOW_LEN{1'b0}};
    end else begin
      if (advance) begin
        head_nxt_s   = head_r + INDEX_LEN'(1'b1);
        bitmap_nxt_s = bitmap_r >> 1'b1;
      end else begin
        head_nxt_s   = head_r;
        bitmap_nxt_s = bitmap_r;
      end
      if (cls == CLS_NEW) begin
        bitmap_nxt_s = bitmap_nxt_s | set_mask_s;
      end else begin
        bitmap_nxt_s = bitmap_nxt_s;
      end
    end
  end

  // Window state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_r   <= {INDEX_LEN{1'b0}};
      bitmap_r <= {WINDOW_LEN{1'b0}};
    end else begin
      head_r   <= head_nxt_s;
      bitmap_r <= bitmap_nxt_s;
    end
  end

endmodule

// File: rtl/ffcp_rx_sack_server.sv
// FFCP receive-side ack server: window tracking plus coalesced ack handshake.
// Build option FFCP_SACK_EN publishes the SACK bitmap and acks out-of-order holes.
module ffcp_rx_sack_server
  import ffcp_rx_sack_server_pkg::*;
#(
  parameter int INDEX_LEN  = FFCP_INDEX_LEN,
  parameter int WINDOW_LEN = FFCP_WINDOW_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  syn,
  input  logic                  inclk,
  input  logic [INDEX_LEN-1:0]  in_index,
  input  logic                  downstream_done,
  output logic                  outclk,
  output logic [INDEX_LEN-1:0]  out_index,
  output logic [WINDOW_LEN-1:0] out_sack,
  output logic                  out_dup,
  output logic                  out_ignored
);

`ifdef FFCP_SACK_EN
  localparam bit SACK_EN = 1'b1;
`else
  localparam bit SACK_EN = 1'b0;
`endif

  if (WINDOW_LEN < 1 || WINDOW_LEN > (1 << (INDEX_LEN - 1))) begin : g_bad_window
    $error("ffcp_rx_sack_server: WINDOW_LEN must be within 1..2^(INDEX_LEN-1)");
  end

  logic [INDEX_LEN-1:0]  head_s;
  logic [WINDOW_LEN-1:0] bitmap_s;
  logic                  advance_s;
  ffcp_cls_e             cls_s;
  logic                  new_ooo_s;
  logic                  ack_pending_r;
  logic                  downstream_rdy_r;
  logic                  ack_set_s;
  logic                  outclk_s;

  ffcp_rx_window #(
    .INDEX_LEN  (INDEX_LEN),
    .WINDOW_LEN (WINDOW_LEN)
  ) u_window (
    .clk      (clk),
    .rst      (rst),
    .syn      (syn),
    .inclk    (inclk),
    .in_index (in_index),
    .head     (head_s),
    .bitmap   (bitmap_s),
    .advance  (advance_s),
    .cls      (cls_s),
    .new_ooo  (new_ooo_s)
  );

  // Hold the ack back while the head can still advance, so acks coalesce.
  assign outclk_s  = ack_pending_r && !bitmap_s[0] && downstream_rdy_r && !inclk && !syn;
  assign ack_set_s = advance_s || (cls_s == CLS_DUP) || syn || (SACK_EN && new_ooo_s);

  assign outclk      = outclk_s;
  assign out_index   = head_s;
  assign out_sack    = SACK_EN ? bitmap_s : {WINDOW_LEN{1'b0}};
  assign out_dup     = (cls_s == CLS_DUP);
  assign out_ignored = (cls_s == CLS_IGN);

  // Ack handshake: pending request and transmitter-ready flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_pending_r    <= 1'b0;
      downstream_rdy_r <= 1'b1;
    end else begin
      if (ack_set_s) begin
        ack_pending_r <= 1'b1;
      end else if (outclk_s) begin
        ack_pending_r <= 1'b0;
      end else begin
        ack_pending_r <= ack_pending_r;
      end
      if (outclk_s) begin
        downstream_rdy_r <= 1'b0;
      end else if (downstream_done) begin
        downstream_rdy_r <= 1'b1;
      end else begin
        downstream_rdy_r <= downstream_rdy_r;
      end
    end
  end

endmodule

// File: tb/tb_ffcp_rx_sack_server.sv
// Self-checking bench for ffcp_rx_sack_server: directed vector table,
// hand-written corner sequences, and random traffic against a set-based model.
module tb_ffcp_rx_sack_server;

  localparam int IL = 6;
  localparam int WL = 8;
  localparam int NI = 64;
`ifdef FFCP_SACK_EN
  localparam bit SACK = 1'b1;
`else
  localparam bit SACK = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          syn;
  logic          inclk;
  logic [IL-1:0] in_index;
  logic          downstream_done;
  logic          outclk;
  logic [IL-1:0] out_index;
  logic [WL-1:0] out_sack;
  logic          out_dup;
  logic          out_ignored;

  int errors = 0;
  int checks = 0;

  // Reference model: set of received-but-not-yet-passed absolute indices.
  int m_head;
  bit m_rcv [NI];
  bit m_pend;
  bit m_rdy;

  ffcp_rx_sack_server dut (
    .clk             (clk),
    .rst             (rst),
    .syn             (syn),
    .inclk           (inclk),
    .in_index        (in_index),
    .downstream_done (downstream_done),
    .outclk          (outclk),
    .out_index       (out_index),
    .out_sack        (out_sack),
    .out_dup         (out_dup),
    .out_ignored     (out_ignored)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit            s;
    bit            ic;
    int            idx;
    bit            d;
    bit            oc_sack;
    bit            oc_nosack;
    int            oidx;
    logic [WL-1:0] sack;
    bit            dup;
    bit            ign;
  } vec_t;

  vec_t tbl [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_head = 0;
    for (int i = 0; i < NI; i++) m_rcv[i] = 1'b0;
    m_pend = 1'b0;
    m_rdy  = 1'b1;
  endtask

  task automatic drive(input bit s, input bit ic, input int idx, input bit d);
    @(negedge clk);
    syn             = s;
    inclk           = ic;
    in_index        = idx[IL-1:0];
    downstream_done = d;
    #2;
  endtask

  // One cycle: drive, compare against the model, then advance the model.
  task automatic step(input bit s, input bit ic, input int idx, input bit d);
    int            off;
    bit            b0, e_new, e_dup, e_ign, e_oc;
    logic [WL-1:0] e_sack;
    drive(s, ic, idx, d);
    off   = (idx + NI - m_head) % NI;
    b0    = m_rcv[m_head];
    e_new = 1'b0; e_dup = 1'b0; e_ign = 1'b0;
    if (ic && !s) begin
      if (off < WL) begin
        if (m_rcv[idx]) e_dup = 1'b1;
        else            e_new = 1'b1;
      end else if (off >= NI - WL) e_dup = 1'b1;
      else                         e_ign = 1'b1;
    end
    e_oc = m_pend && !b0 && m_rdy && !ic && !s;
    for (int k = 0; k < WL; k++) e_sack[k] = SACK && m_rcv[(m_head + k) % NI];
    check("m_outclk", 32'(outclk), 32'(e_oc));
    check("m_dup", 32'(out_dup), 32'(e_dup));
    check("m_ignored", 32'(out_ignored), 32'(e_ign));
    check("m_index", 32'(out_index), 32'(m_head));
    check("m_sack", 32'(out_sack), 32'(e_sack));
    if (s) begin
      for (int i = 0; i < NI; i++) m_rcv[i] = 1'b0;
      m_head = 1;
      m_pend = 1'b1;
    end else begin
      if (b0) begin
        m_rcv[m_head] = 1'b0;
        m_head = (m_head + 1) % NI;
        m_pend = 1'b1;
      end
      if (e_new) begin
        m_rcv[idx] = 1'b1;
        if (SACK && off != 0) m_pend = 1'b1;
      end
      if (e_dup) m_pend = 1'b1;
      if (e_oc)  m_pend = 1'b0;
    end
    if (e_oc)   m_rdy = 1'b0;
    else if (d) m_rdy = 1'b1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_outclk"}, 32'(outclk), 32'd0);
    check({name, "_index"}, 32'(out_index), 32'd0);
    check({name, "_sack"}, 32'(out_sack), 32'd0);
    check({name, "_dup"}, 32'(out_dup), 32'd0);
    check({name, "_ignored"}, 32'(out_ignored), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    syn = 1'b0; inclk = 1'b0; in_index = '0; downstream_done = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    check_all_zero("rst_async");
    @(negedge clk);
    rst = 1'b1;
    m_reset();
  endtask

  task automatic wait_ack(input string name, input int exp_idx);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b0, 1'b0, 0, 1'b1);
      if (outclk) begin
        seen = 1'b1;
        check(name, 32'(out_index), 32'(exp_idx));
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: no outclk within 20 cycles, expected index %0d", name, exp_idx);
    end
  endtask

  function automatic vec_t v(bit s, bit ic, int idx, bit d, bit ocs, bit ocn,
                             int oidx, logic [WL-1:0] sk, bit dup, bit ign);
    vec_t r;
    r.s = s; r.ic = ic; r.idx = idx; r.d = d; r.oc_sack = ocs; r.oc_nosack = ocn;
    r.oidx = oidx; r.sack = sk; r.dup = dup; r.ign = ign;
    return r;
  endfunction

  initial begin
    rst = 1'b0; syn = 1'b0; inclk = 1'b0; in_index = '0; downstream_done = 1'b0;
    m_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    //            s  ic idx d  ocS ocN oidx sack   dup ign
    tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 0, 8'h01, 0, 0));
    tbl.push_back(v(0, 1, 2, 0, 0, 0, 1, 8'h01, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 2, 8'h01, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 3, 8'h00, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 3, 8'h00, 0, 0));
    tbl.push_back(v(0, 1, 2, 0, 0, 0, 3, 8'h00, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 3, 8'h00, 0, 0));
    tbl.push_back(v(0, 1, 20, 0, 0, 0, 3, 8'h00, 0, 1));
    tbl.push_back(v(0, 1, 3, 0, 0, 0, 3, 8'h00, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 3, 8'h01, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 4, 8'h00, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 4, 8'h00, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 4, 8'h00, 0, 0));
    tbl.push_back(v(0, 1, 2, 1, 0, 0, 4, 8'h00, 1, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 1, 4, 8'h00, 0, 0));
    tbl.push_back(v(0, 1, 2, 0, 0, 0, 4, 8'h00, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 4, 8'h00, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 4, 8'h00, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 4, 8'h00, 0, 0));
    tbl.push_back(v(0, 1, 6, 1, 0, 0, 4, 8'h00, 0, 0));
    tbl.push_back(v(0, 1, 5, 0, 0, 0, 4, 8'h04, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 4, 8'h06, 0, 0));
    tbl.push_back(v(0, 1, 4, 1, 0, 0, 4, 8'h06, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 4, 8'h07, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 5, 8'h03, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 6, 8'h01, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 1, 7, 8'h00, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].s, tbl[i].ic, tbl[i].idx, tbl[i].d);
      check($sformatf("tbl%0d_outclk", i), 32'(outclk),
            32'(SACK ? tbl[i].oc_sack : tbl[i].oc_nosack));
      check($sformatf("tbl%0d_index", i), 32'(out_index), 32'(tbl[i].oidx));
      check($sformatf("tbl%0d_sack", i), 32'(out_sack), 32'(SACK ? tbl[i].sack : 8'h00));
      check($sformatf("tbl%0d_dup", i), 32'(out_dup), 32'(tbl[i].dup));
      check($sformatf("tbl%0d_ignored", i), 32'(out_ignored), 32'(tbl[i].ign));
    end

    // Wrap-around: run the head up to 62, then across the 63 -> 0 boundary.
    do_reset();
    for (int i = 0; i < 62; i++) step(1'b0, 1'b1, i, 1'b1);
    step(1'b0, 1'b1, 62, 1'b1);
    step(1'b0, 1'b1, 63, 1'b1);
    step(1'b0, 1'b1, 0, 1'b1);
    step(1'b0, 1'b1, 1, 1'b1);
    wait_ack("wrap_ack", 2);
    step(1'b0, 1'b1, 58, 1'b1);
    check("wrap_stale_dup", 32'(out_dup), 32'd1);

    // syn restart with buffered out-of-order bits, then syn colliding with inclk.
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, i, 1'b1);
    step(1'b0, 1'b1, 42, 1'b1);
    step(1'b0, 1'b1, 44, 1'b1);
    wait_ack("pre_syn_ack", 40);
    step(1'b1, 1'b0, 0, 1'b1);
    wait_ack("syn_ack", 1);
    step(1'b1, 1'b1, 5, 1'b1);
    check("syn_inclk_dup", 32'(out_dup), 32'd0);
    check("syn_inclk_ign", 32'(out_ignored), 32'd0);
    wait_ack("syn2_ack", 1);
    check("syn2_sack", 32'(out_sack), 32'd0);

    // Mid-stream reset with state present.
    for (int i = 1; i < 6; i++) step(1'b0, 1'b1, i + 1, 1'b0);
    do_reset();

    // Random traffic near and around the window.
    for (int n = 0; n < 2500; n++) begin
      bit s, ic, d;
      int idx;
      s  = ($urandom_range(0, 39) == 0);
      ic = ($urandom_range(0, 1) == 1);
      d  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) < 8) idx = (m_head + NI + $urandom_range(0, 24) - 10) % NI;
      else                          idx = $urandom_range(0, NI - 1);
      step(s, ic, idx, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
